// File: rtl/color_config_arbiter_pkg.sv
// Shared types and constants for the Color Manager configuration-bus arbiter.
package color_config_arbiter_pkg;

  localparam int C_ADDR_WIDTH       = 4;
  localparam int C_DATA_WIDTH       = 14;
  localparam int DEF_TIMEOUT_CYCLES = 15;
  localparam int DEF_ERR_CNT_WIDTH  = 8;
  localparam int TMO_CNT_WIDTH      = 8;

  localparam logic C_VALID_ACTIVE = 1'b0;
  localparam logic C_RDY_ACTIVE   = 1'b0;

  localparam logic [C_ADDR_WIDTH-1:0] ADDR_VGA_CONFIG  = 4'h0;
  localparam logic [C_ADDR_WIDTH-1:0] ADDR_VGA_COLOR   = 4'h1;
  localparam logic [C_ADDR_WIDTH-1:0] ADDR_VGA_QUADRAN = 4'h2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

endpackage

// File: rtl/color_config_arbiter_if.sv
// Requester handshakes plus the Color Manager config bus, seen from the arbiter (master) or its environment (slave).
interface color_config_arbiter_if;
  import color_config_arbiter_pkg::*;

  logic                    Req0_Valid;
  logic [C_ADDR_WIDTH-1:0] Req0_Addr;
  logic [C_DATA_WIDTH-1:0] Req0_Data;
  logic                    Req0_Ack;
  logic                    Req0_Err;
  logic                    Req1_Valid;
  logic [C_ADDR_WIDTH-1:0] Req1_Addr;
  logic [C_DATA_WIDTH-1:0] Req1_Data;
  logic                    Req1_Ack;
  logic                    Req1_Err;
  logic [C_ADDR_WIDTH-1:0] C_Addr;
  logic [C_DATA_WIDTH-1:0] C_Data;
  logic                    C_Valid;
  logic                    C_Rdy;

  modport master (
    input  Req0_Valid, Req0_Addr, Req0_Data, Req1_Valid, Req1_Addr, Req1_Data, C_Rdy,
    output Req0_Ack, Req0_Err, Req1_Ack, Req1_Err, C_Addr, C_Data, C_Valid
  );

  modport slave (
    output Req0_Valid, Req0_Addr, Req0_Data, Req1_Valid, Req1_Addr, Req1_Data, C_Rdy,
    input  Req0_Ack, Req0_Err, Req1_Ack, Req1_Err, C_Addr, C_Data, C_Valid
  );

endinterface

// File: rtl/color_config_arbiter_rr_arbiter_2.sv
// Two-way round-robin grant: a tie goes to the requester that was not granted last.
module rr_arbiter_2 (
  input  logic [1:0] i_Req,
  input  logic       i_Last_Grant,
  output logic [1:0] o_Grant
);

  // One-hot grant selection
  always_comb begin
    o_Grant = 2'b00;
    case (i_Req)
      2'b01:   o_Grant = 2'b01;
      2'b10:   o_Grant = 2'b10;
      2'b11:   o_Grant = i_Last_Grant ? 2'b01 : 2'b10;
      default: o_Grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/color_config_arbiter.sv
// Sole master of the Color Manager config bus: arbitrates two requesters, strobes one write,
// and reports ack or timeout back to the granted requester.
module color_config_arbiter
  import color_config_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int ERR_CNT_WIDTH  = DEF_ERR_CNT_WIDTH
) (
  input  logic                     Clk,
  input  logic                     Rst,
  color_config_arbiter_if.master   io_bus,
  output logic                     o_Busy,
  output logic [ERR_CNT_WIDTH-1:0] o_Err_Count
);

  localparam logic [TMO_CNT_WIDTH-1:0] TMO_LAST = TMO_CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  state_t                     r_State,     w_State_Nxt;
  logic [C_ADDR_WIDTH-1:0]    r_C_Addr,    w_C_Addr_Nxt;
  logic [C_DATA_WIDTH-1:0]    r_C_Data,    w_C_Data_Nxt;
  logic                       r_C_Valid,   w_C_Valid_Nxt;
  logic [1:0]                 r_Ack,       w_Ack_Nxt;
  logic [1:0]                 r_Err,       w_Err_Nxt;
  logic [TMO_CNT_WIDTH-1:0]   r_Tmo_Cnt,   w_Tmo_Cnt_Nxt;
  logic [ERR_CNT_WIDTH-1:0]   r_Err_Count, w_Err_Count_Nxt;
  logic                       r_Last_Grant, w_Last_Grant_Nxt;
  logic                       r_Owner,     w_Owner_Nxt;
  logic                       r_Busy;
  logic [1:0]                 w_Req;
  logic [1:0]                 w_Grant;

  // A requester still sees its own Ack/Err this cycle and has not yet dropped Valid;
  // masking it stops the same write being strobed a second time.
  assign w_Req = {io_bus.Req1_Valid & ~(r_Ack[1] | r_Err[1]),
                  io_bus.Req0_Valid & ~(r_Ack[0] | r_Err[0])};

  rr_arbiter_2 u_rr_arbiter_2 (
    .i_Req        (w_Req),
    .i_Last_Grant (r_Last_Grant),
    .o_Grant      (w_Grant)
  );

  // Next-state and next-output logic of the bus FSM
  always_comb begin
    w_State_Nxt      = r_State;
    w_C_Addr_Nxt     = r_C_Addr;
    w_C_Data_Nxt     = r_C_Data;
    w_C_Valid_Nxt    = ~C_VALID_ACTIVE;
    w_Ack_Nxt        = 2'b00;
    w_Err_Nxt        = 2'b00;
    w_Tmo_Cnt_Nxt    = r_Tmo_Cnt;
    w_Err_Count_Nxt  = r_Err_Count;
    w_Last_Grant_Nxt = r_Last_Grant;
    w_Owner_Nxt      = r_Owner;
    case (r_State)
      ST_IDLE: begin
        if (w_Grant != 2'b00) begin
          w_Owner_Nxt      = w_Grant[1];
          w_Last_Grant_Nxt = w_Grant[1];
          w_C_Addr_Nxt     = w_Grant[1] ? io_bus.Req1_Addr : io_bus.Req0_Addr;
          w_C_Data_Nxt     = w_Grant[1] ? io_bus.Req1_Data : io_bus.Req0_Data;
          w_C_Valid_Nxt    = C_VALID_ACTIVE;
          w_State_Nxt      = ST_ISSUE;
        end else begin
          w_State_Nxt = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        // C_Rdy is deliberately not looked at here so a stale pulse cannot ack this write
        w_Tmo_Cnt_Nxt = {TMO_CNT_WIDTH{1'b0}};
        w_State_Nxt   = ST_WAIT;
      end
      ST_WAIT: begin
        if (io_bus.C_Rdy == C_RDY_ACTIVE) begin
          w_Ack_Nxt   = r_Owner ? 2'b10 : 2'b01;
          w_State_Nxt = ST_IDLE;
        end else if (r_Tmo_Cnt == TMO_LAST) begin
          w_Err_Nxt       = r_Owner ? 2'b10 : 2'b01;
          w_Err_Count_Nxt = (&r_Err_Count) ? r_Err_Count : r_Err_Count + ERR_CNT_WIDTH'(1);
          w_State_Nxt     = ST_IDLE;
        end else begin
          w_Tmo_Cnt_Nxt = r_Tmo_Cnt + TMO_CNT_WIDTH'(1);
        end
      end
      default: begin
        w_State_Nxt = ST_IDLE;
      end
    endcase
  end

  // State and registered-output update; reset aborts any write in flight
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_State      <= ST_IDLE;
      r_C_Addr     <= {C_ADDR_WIDTH{1'b0}};
      r_C_Data     <= {C_DATA_WIDTH{1'b0}};
      r_C_Valid    <= ~C_VALID_ACTIVE;
      r_Ack        <= 2'b00;
      r_Err        <= 2'b00;
      r_Tmo_Cnt    <= {TMO_CNT_WIDTH{1'b0}};
      r_Err_Count  <= {ERR_CNT_WIDTH{1'b0}};
      r_Last_Grant <= 1'b1;
      r_Owner      <= 1'b0;
      r_Busy       <= 1'b0;
    end else begin
      r_State      <= w_State_Nxt;
      r_C_Addr     <= w_C_Addr_Nxt;
      r_C_Data     <= w_C_Data_Nxt;
      r_C_Valid    <= w_C_Valid_Nxt;
      r_Ack        <= w_Ack_Nxt;
      r_Err        <= w_Err_Nxt;
      r_Tmo_Cnt    <= w_Tmo_Cnt_Nxt;
      r_Err_Count  <= w_Err_Count_Nxt;
      r_Last_Grant <= w_Last_Grant_Nxt;
      r_Owner      <= w_Owner_Nxt;
      r_Busy       <= (w_State_Nxt != ST_IDLE);
    end
  end

  assign io_bus.C_Addr   = r_C_Addr;
  assign io_bus.C_Data   = r_C_Data;
  assign io_bus.C_Valid  = r_C_Valid;
  assign io_bus.Req0_Ack = r_Ack[0];
  assign io_bus.Req1_Ack = r_Ack[1];
  assign io_bus.Req0_Err = r_Err[0];
  assign io_bus.Req1_Err = r_Err[1];
  assign o_Busy          = r_Busy;
  assign o_Err_Count     = r_Err_Count;

endmodule

// File: tb/tb_color_config_arbiter.sv
// Directed bench for color_config_arbiter with a small Color Manager model on the config bus.
module tb_color_config_arbiter;
  import color_config_arbiter_pkg::*;

  localparam int TMO = 15;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic       busy;
  logic [7:0] err_count;
  int         errors = 0;
  int         checks = 0;

  logic        ack_en   = 1'b1;
  logic        stale    = 1'b0;
  logic        ack_pend;
  logic [11:0] left_up  = 12'h000;

  color_config_arbiter_if bus ();

  color_config_arbiter #(.TIMEOUT_CYCLES(TMO), .ERR_CNT_WIDTH(8)) dut (
    .Clk         (Clk),
    .Rst         (Rst),
    .io_bus      (bus.master),
    .o_Busy      (busy),
    .o_Err_Count (err_count)
  );

  always #5 Clk = ~Clk;

  // Color Manager model: decodes addresses 0..2 and acks one cycle after the strobe
  always @(posedge Clk or posedge Rst) begin
    if (Rst) ack_pend <= 1'b0;
    else     ack_pend <= (bus.C_Valid === 1'b0) && ack_en && (bus.C_Addr <= ADDR_VGA_QUADRAN);
  end

  always @(posedge Clk) begin
    if (bus.C_Valid === 1'b0 && bus.C_Addr == ADDR_VGA_COLOR && bus.C_Data[13:12] == 2'b00)
      left_up <= bus.C_Data[11:0];
  end

  assign bus.C_Rdy = ~(ack_pend | stale);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge Clk);
  endtask

  function automatic logic [31:0] flags();
    return {28'd0, bus.Req1_Ack, bus.Req1_Err, bus.Req0_Ack, bus.Req0_Err};
  endfunction

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int idx;
    int strobes;
    int early;
    int n_err;
    int cyc;
    logic got;
    logic [1:0] order [4];
    order[0] = 2'b01; order[1] = 2'b10; order[2] = 2'b01; order[3] = 2'b10;

    bus.Req0_Valid = 1'b0; bus.Req0_Addr = 4'h0; bus.Req0_Data = 14'h0000;
    bus.Req1_Valid = 1'b0; bus.Req1_Addr = 4'h0; bus.Req1_Data = 14'h0000;

    // Reset
    repeat (3) @(posedge Clk);
    step(); Rst = 1'b0;
    check("rst_cvalid", 32'(bus.C_Valid), 32'(1'b1));
    check("rst_busy", 32'(busy), 32'(1'b0));
    check("rst_errcnt", 32'(err_count), 32'(8'd0));
    check("rst_flags", flags(), 32'd0);
    check("rst_caddr", 32'(bus.C_Addr), 32'(4'h0));

    // Single write from Req0
    bus.Req0_Addr = ADDR_VGA_COLOR; bus.Req0_Data = 14'h0F00; bus.Req0_Valid = 1'b1;
    step();
    check("w1_strobe", 32'(bus.C_Valid), 32'(1'b0));
    check("w1_cdata", 32'(bus.C_Data), 32'(14'h0F00));
    check("w1_caddr", 32'(bus.C_Addr), 32'(ADDR_VGA_COLOR));
    check("w1_busy", 32'(busy), 32'(1'b1));
    step();
    check("w1_strobe_end", 32'(bus.C_Valid), 32'(1'b1));
    check("w1_no_early_ack", flags(), 32'd0);
    step();
    check("w1_ack", flags(), 32'h2);
    check("w1_busy_idle", 32'(busy), 32'(1'b0));
    bus.Req0_Valid = 1'b0;
    step();
    check("w1_ack_pulse", flags(), 32'd0);
    check("w1_no_restrobe", 32'(bus.C_Valid), 32'(1'b1));
    check("w1_left_up", 32'(left_up), 32'(12'hF00));

    // Requester drops Valid while granted: Ack still delivered
    bus.Req1_Addr = ADDR_VGA_CONFIG; bus.Req1_Data = 14'h0123; bus.Req1_Valid = 1'b1;
    step();
    check("drop_strobe", 32'(bus.C_Data), 32'(14'h0123));
    bus.Req1_Valid = 1'b0;
    step(); step();
    check("drop_ack1", flags(), 32'h8);

    // Tie after reset: Req0, Req1, Req0, Req1
    Rst = 1'b1; repeat (3) step(); Rst = 1'b0;
    bus.Req0_Addr = ADDR_VGA_COLOR;   bus.Req0_Data = 14'h1AAA;
    bus.Req1_Addr = ADDR_VGA_QUADRAN; bus.Req1_Data = 14'h0002;
    bus.Req0_Valid = 1'b1; bus.Req1_Valid = 1'b1;
    idx = 0;
    for (int c = 0; c < 30 && idx < 4; c++) begin
      step();
      if (bus.C_Valid === 1'b0)
        check("tie_cdata", 32'(bus.C_Data), (order[idx] == 2'b10) ? 32'(14'h0002) : 32'(14'h1AAA));
      if (bus.Req0_Ack === 1'b1 || bus.Req1_Ack === 1'b1) begin
        check("tie_order", 32'({bus.Req1_Ack, bus.Req0_Ack}), 32'(order[idx]));
        idx++;
        if (idx == 4) begin
          bus.Req0_Valid = 1'b0; bus.Req1_Valid = 1'b0;
        end
      end
    end
    check("tie_count", 32'(idx), 32'd4);
    bus.Req0_Valid = 1'b0; bus.Req1_Valid = 1'b0;
    step(); step();
    check("tie_idle", 32'(busy), 32'(1'b0));

    // Timeout on an undecoded address
    bus.Req1_Addr = 4'hF; bus.Req1_Data = 14'h3FFF; bus.Req1_Valid = 1'b1;
    step();
    check("tmo_strobe", 32'(bus.C_Valid), 32'(1'b0));
    strobes = 0; early = 0;
    for (int k = 0; k < TMO; k++) begin
      step();
      if (bus.C_Valid !== 1'b1) strobes++;
      if (flags() != 32'd0) early++;
    end
    check("tmo_one_strobe", 32'(strobes), 32'd0);
    check("tmo_no_early", 32'(early), 32'd0);
    step();
    check("tmo_err1", flags(), 32'h4);
    check("tmo_errcnt1", 32'(err_count), 32'(8'd1));
    bus.Req1_Valid = 1'b0;
    step();

    // 299 more timeouts: counter saturates
    n_err = 0;
    for (int r = 0; r < 299; r++) begin
      bus.Req1_Valid = 1'b1;
      got = 1'b0;
      for (int c = 0; c < 40 && !got; c++) begin
        step();
        if (bus.Req1_Err === 1'b1) got = 1'b1;
      end
      if (got) n_err++;
      bus.Req1_Valid = 1'b0;
      step();
    end
    check("sat_err_pulses", 32'(n_err), 32'd299);
    check("sat_errcnt", 32'(err_count), 32'(8'd255));

    // Stale C_Rdy during ISSUE is ignored
    ack_en = 1'b0;
    bus.Req0_Addr = ADDR_VGA_COLOR; bus.Req0_Data = 14'h0ABC; bus.Req0_Valid = 1'b1;
    step();
    check("stale_strobe", 32'(bus.C_Valid), 32'(1'b0));
    stale = 1'b1;
    step();
    stale = 1'b0;
    check("stale_no_ack", flags(), 32'd0);
    check("stale_busy", 32'(busy), 32'(1'b1));
    cyc = 0; early = 0; got = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      step();
      cyc++;
      if (bus.Req0_Ack === 1'b1) early++;
      if (bus.Req0_Err === 1'b1) got = 1'b1;
    end
    check("stale_err", 32'(got), 32'(1'b1));
    check("stale_err_time", 32'(cyc), 32'(TMO));
    check("stale_never_ack", 32'(early), 32'd0);
    check("stale_errcnt_sat", 32'(err_count), 32'(8'd255));
    bus.Req0_Valid = 1'b0;
    ack_en = 1'b1;
    step();

    // Reset in WAIT aborts the write, then Req0 wins a tie
    bus.Req1_Addr = 4'hF; bus.Req1_Valid = 1'b1;
    step(); step(); step();
    check("mid_busy_pre", 32'(busy), 32'(1'b1));
    Rst = 1'b1;
    #1;
    check("mid_cvalid", 32'(bus.C_Valid), 32'(1'b1));
    check("mid_busy", 32'(busy), 32'(1'b0));
    check("mid_flags", flags(), 32'd0);
    bus.Req1_Valid = 1'b0;
    step(); step();
    Rst = 1'b0;
    check("mid_errcnt", 32'(err_count), 32'(8'd0));
    bus.Req0_Addr = ADDR_VGA_COLOR;  bus.Req0_Data = 14'h0555;
    bus.Req1_Addr = ADDR_VGA_CONFIG; bus.Req1_Data = 14'h0001;
    bus.Req0_Valid = 1'b1; bus.Req1_Valid = 1'b1;
    step();
    check("mid_prio_data", 32'(bus.C_Data), 32'(14'h0555));
    step(); step();
    check("mid_prio_ack0", flags(), 32'h2);
    bus.Req0_Valid = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      step();
      if (bus.Req1_Ack === 1'b1) got = 1'b1;
    end
    check("mid_ack1", 32'(got), 32'(1'b1));
    bus.Req1_Valid = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
